// File: rtl/mem_access_unit.sv
// MEM-stage data-memory initiator: single-word and two-beat (PC push/pop) loads and stores.
// Optional MAU_ALIGN_CHECK_EN rejects odd-address wide requests with a one-cycle err pulse.
module mem_access_unit #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned ADDR_SIZE = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic                     req_write,
    input  logic                     req_wide,
    input  logic [ADDR_SIZE-1:0]     req_addr,
    input  logic [2*WORD_SIZE-1:0]   req_wdata,
    output logic                     req_ready,
    output logic                     resp_valid,
    output logic [2*WORD_SIZE-1:0]   resp_rdata,
    output logic                     err,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDR_SIZE-1:0]     mem_addr,
    output logic [WORD_SIZE-1:0]     mem_wd,
    input  logic [WORD_SIZE-1:0]     mem_rd
);

    typedef enum logic [2:0] {
        StIdle, StWrHi, StWrLo, StRdHi, StRdLo, StRdCap, StRdDone, StAlignErr
    } state_e;

    state_e                 state_q, state_d;
    logic                   wide_q, wide_d;
    logic [ADDR_SIZE-1:0]   addr_q, addr_d;
    logic [2*WORD_SIZE-1:0] wdata_q, wdata_d;
    logic [WORD_SIZE-1:0]   hi_q, hi_d;

    logic                   req_ready_d, resp_valid_d, err_d, mem_read_d, mem_write_d;
    logic [2*WORD_SIZE-1:0] resp_rdata_d;
    logic [ADDR_SIZE-1:0]   mem_addr_d;
    logic [WORD_SIZE-1:0]   mem_wd_d;

    always_comb begin
        state_d      = state_q;
        wide_d       = wide_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        hi_d         = hi_q;
        resp_rdata_d = resp_rdata;

        unique case (state_q)
            StIdle, StRdDone: begin
                state_d = StIdle;
                if (req_valid) begin
                    wide_d  = req_wide;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (req_write) state_d = req_wide ? StWrHi : StWrLo;
                    else           state_d = req_wide ? StRdHi : StRdLo;
`ifdef MAU_ALIGN_CHECK_EN
                    if (req_wide && req_addr[0]) state_d = StAlignErr;
`endif
                end
            end
            StWrHi: state_d = StWrLo;
            StWrLo: state_d = StIdle;
            StRdHi: state_d = StRdLo;
            StRdLo: begin
                // Memory is one edge behind the address: mem_rd now carries the hi word.
                if (wide_q) hi_d = mem_rd;
                state_d = StRdCap;
            end
            StRdCap: begin
                resp_rdata_d = wide_q ? {hi_q, mem_rd} : {{WORD_SIZE{1'b0}}, mem_rd};
                state_d      = StRdDone;
            end
            StAlignErr: state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so every pin comes straight from a flop.
    always_comb begin
        req_ready_d  = (state_d == StIdle) || (state_d == StRdDone);
        resp_valid_d = (state_d == StRdDone);
`ifdef MAU_ALIGN_CHECK_EN
        err_d        = (state_d == StAlignErr);
`else
        err_d        = 1'b0;
`endif
        mem_read_d   = (state_d == StRdHi) || (state_d == StRdLo);
        mem_write_d  = (state_d == StWrHi) || (state_d == StWrLo);
        mem_addr_d   = mem_addr;
        mem_wd_d     = mem_wd;
        unique case (state_d)
            StWrHi: begin
                mem_addr_d = addr_d;
                mem_wd_d   = wdata_d[2*WORD_SIZE-1:WORD_SIZE];
            end
            StWrLo: begin
                mem_addr_d = wide_d ? addr_d + ADDR_SIZE'(1) : addr_d;
                mem_wd_d   = wdata_d[WORD_SIZE-1:0];
            end
            StRdHi: mem_addr_d = addr_d;
            StRdLo: mem_addr_d = wide_d ? addr_d + ADDR_SIZE'(1) : addr_d;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            wide_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            hi_q       <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            err        <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wd     <= '0;
        end else begin
            state_q    <= state_d;
            wide_q     <= wide_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            hi_q       <= hi_d;
            req_ready  <= req_ready_d;
            resp_valid <= resp_valid_d;
            resp_rdata <= resp_rdata_d;
            err        <= err_d;
            mem_read   <= mem_read_d;
            mem_write  <= mem_write_d;
            mem_addr   <= mem_addr_d;
            mem_wd     <= mem_wd_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table plus hand sequences for back-to-back
// acceptance, mid-load reset and odd wide addresses (with or without MAU_ALIGN_CHECK_EN).
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write, req_wide;
    logic [10:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready, resp_valid, err, mem_read, mem_write;
    logic [31:0] resp_rdata;
    logic [10:0] mem_addr;
    logic [15:0] mem_wd;
    logic [15:0] mem_rd;

    logic [15:0] mem [0:2047];

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] last_rdata = 32'h0;

    mem_access_unit #(.WORD_SIZE(16), .ADDR_SIZE(11)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_wide   (req_wide),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .err        (err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    always #5 clk = ~clk;

    // Synchronous memory: read data appears on the edge that samples mem_read.
    always @(posedge clk) begin
        if (mem_read) mem_rd <= mem[mem_addr];
        else if (mem_write) mem[mem_addr] <= mem_wd;
    end

    typedef struct {
        logic        wr;
        logic        wide;
        logic [10:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          cyc;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input logic ok, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk(req_ready == 1'b1,   {tag, "_ready"},  32'(req_ready),  32'h1);
        chk(resp_valid == 1'b0,  {tag, "_rvalid"}, 32'(resp_valid), 32'h0);
        chk(resp_rdata == 32'h0, {tag, "_rdata"},  resp_rdata,      32'h0);
        chk(err == 1'b0,         {tag, "_err"},    32'(err),        32'h0);
        chk(!mem_read && !mem_write, {tag, "_rw"}, {30'h0, mem_read, mem_write}, 32'h0);
        chk(mem_addr == 11'h0,   {tag, "_maddr"},  32'(mem_addr),   32'h0);
        chk(mem_wd == 16'h0,     {tag, "_mwd"},    32'(mem_wd),     32'h0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          got;
        logic        both, saw_resp, rdy_at_resp;
        logic [31:0] rd;
        logic [10:0] lo_addr;
        string       t;
        t = $sformatf("v%0d", idx);
        got = 0; both = 1'b0; saw_resp = 1'b0; rdy_at_resp = 1'b0; rd = 32'h0;
        @(negedge clk);
        req_write = v.wr; req_wide = v.wide; req_addr = v.addr; req_wdata = v.wdata;
        req_valid = 1'b1;
        chk(req_ready == 1'b1, {t, "_ready_idle"}, 32'(req_ready), 32'h1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 12 && got == 0; c++) begin
            @(negedge clk);
            if (mem_read && mem_write) both = 1'b1;
            if (v.wr) begin
                if (resp_valid) saw_resp = 1'b1;
                if (req_ready) got = c;
            end else if (resp_valid) begin
                got = c; rd = resp_rdata; rdy_at_resp = req_ready;
            end
        end
        chk(!both, {t, "_rw_exclusive"}, 32'(both), 32'h0);
        if (v.wr) begin
            chk(got - 1 == v.cyc, {t, "_store_busy"}, 32'(got - 1), 32'(v.cyc));
            chk(!saw_resp, {t, "_no_store_resp"}, 32'(saw_resp), 32'h0);
            chk(resp_rdata == last_rdata, {t, "_rdata_hold"}, resp_rdata, last_rdata);
            if (v.wide) begin
                lo_addr = v.addr + 11'd1;
                chk(mem[v.addr] == v.wdata[31:16], {t, "_mem_hi"}, 32'(mem[v.addr]),
                    32'(v.wdata[31:16]));
            end else begin
                lo_addr = v.addr;
            end
            chk(mem[lo_addr] == v.wdata[15:0], {t, "_mem_lo"}, 32'(mem[lo_addr]),
                32'(v.wdata[15:0]));
        end else begin
            chk(got == v.cyc, {t, "_load_latency"}, 32'(got), 32'(v.cyc));
            chk(rd == v.exp, {t, "_load_data"}, rd, v.exp);
            chk(rdy_at_resp, {t, "_ready_at_resp"}, 32'(rdy_at_resp), 32'h1);
            last_rdata = v.exp;
        end
    endtask

    initial begin
        int got;
        logic seen;

        //          wr    wide  addr    wdata          exp            cyc
        vecs[0]  = '{1'b1, 1'b0, 11'h010, 32'h0000BEEF, 32'h0,         1};
        vecs[1]  = '{1'b1, 1'b1, 11'h020, 32'h12345678, 32'h0,         2};
        vecs[2]  = '{1'b0, 1'b1, 11'h020, 32'h0,        32'h12345678,  4};
        vecs[3]  = '{1'b1, 1'b0, 11'h040, 32'h0000A5A5, 32'h0,         1};
        vecs[4]  = '{1'b0, 1'b0, 11'h040, 32'h0,        32'h0000A5A5,  3};
        vecs[5]  = '{1'b1, 1'b1, 11'h7FF, 32'hCAFEF00D, 32'h0,         2};
        vecs[6]  = '{1'b0, 1'b1, 11'h7FF, 32'h0,        32'hCAFEF00D,  4};
        vecs[7]  = '{1'b1, 1'b0, 11'h031, 32'h00001111, 32'h0,         1};
        vecs[8]  = '{1'b1, 1'b0, 11'h032, 32'h00002222, 32'h0,         1};
        vecs[9]  = '{1'b0, 1'b0, 11'h010, 32'h0,        32'h0000BEEF,  3};
        vecs[10] = '{1'b1, 1'b0, 11'h060, 32'hFFFF0042, 32'h0,         1};

        rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_wide = 1'b0;
        req_addr = 11'h0; req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);
        chk(mem[11'h000] == 16'hF00D, "wrap_cell_0", 32'(mem[11'h000]), 32'h0000F00D);

        // Odd wide address.
`ifdef MAU_ALIGN_CHECK_EN
        @(negedge clk);
        req_write = 1'b0; req_wide = 1'b1; req_addr = 11'h031; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk(err == 1'b1, "align_err_pulse", 32'(err), 32'h1);
        chk(req_ready == 1'b0, "align_busy", 32'(req_ready), 32'h0);
        chk(!mem_read && !mem_write, "align_no_access", {30'h0, mem_read, mem_write}, 32'h0);
        @(negedge clk);
        chk(err == 1'b0, "align_err_clear", 32'(err), 32'h0);
        chk(req_ready == 1'b1, "align_ready_back", 32'(req_ready), 32'h1);
        chk(!mem_read && !mem_write, "align_no_access2", {30'h0, mem_read, mem_write}, 32'h0);
`else
        run_vec('{1'b0, 1'b1, 11'h031, 32'h0, 32'h11112222, 4}, 11);
        chk(err == 1'b0, "err_tied_low", 32'(err), 32'h0);
`endif

        // New request accepted in the response cycle.
        @(negedge clk);
        req_write = 1'b0; req_wide = 1'b0; req_addr = 11'h040; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        got = 0;
        for (int c = 1; c <= 12 && got == 0; c++) begin
            @(negedge clk);
            if (resp_valid) got = c;
        end
        chk(got == 3, "b2b_load_latency", 32'(got), 32'd3);
        chk(resp_rdata == 32'h0000A5A5, "b2b_load_data", resp_rdata, 32'h0000A5A5);
        last_rdata = 32'h0000A5A5;
        req_write = 1'b1; req_wide = 1'b0; req_addr = 11'h050; req_wdata = 32'hFFFF3C3C;
        req_valid = 1'b1;
        chk(req_ready == 1'b1, "b2b_ready_in_done", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk(req_ready == 1'b0, "b2b_accepted", 32'(req_ready), 32'h0);
        chk(mem_write && mem_addr == 11'h050 && mem_wd == 16'h3C3C, "b2b_store_beat",
            {4'h0, mem_write, mem_addr, mem_wd}, {4'h0, 1'b1, 11'h050, 16'h3C3C});
        @(negedge clk);
        chk(mem[11'h050] == 16'h3C3C, "b2b_mem", 32'(mem[11'h050]), 32'h00003C3C);

        // Reset during RD_LO of a wide load abandons it.
        @(negedge clk);
        req_write = 1'b0; req_wide = 1'b1; req_addr = 11'h020; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk(mem_read && mem_addr == 11'h021, "rst_in_rdlo", {19'h0, mem_read, mem_addr},
            {19'h0, 1'b1, 11'h021});
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        chk(!seen, "midrst_no_resp", 32'(seen), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
